goto_rep_checker: RTL and testbench

GOTO_REP_CHECKER -- requirements
Module: goto_rep_checker

---
 rtl/goto_rep_pkg.sv | 21 ++
 rtl/goto_rep_ch.sv | 135 +++++++++++++
 rtl/goto_rep_checker.sv | 85 ++++++++
 tb/tb_goto_rep_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/goto_rep_pkg.sv
// goto_rep_pkg
// Shared definitions for the goto-repetition checker: the per-channel state
// encoding and the default parameter values used by goto_rep_checker and
// goto_rep_ch.
package goto_rep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HUNT  = 2'd2,
    CHECK = 2'd3
  } goto_state_e;

  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_START_DLY = 2;
  localparam int DEF_REP_CNT   = 2;
  localparam int DEF_TIMEOUT   = 16;

  localparam int STAT_W = 16;

endpackage

// File: rtl/goto_rep_ch.sv
// goto_rep_ch
// One checker channel: after trig, waits START_DLY-1 cycles, then hunts for
// REP_CNT (not necessarily consecutive) rcv highs within TIMEOUT sampled
// edges, and finally samples cmpl exactly once on the following edge.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   trig, rcv, cmpl   antecedent, repeated event, completion event
//   pass, fail        registered one-cycle result pulses
//   busy              channel not IDLE
//   overlap           registered pulse: trig arrived while busy and was dropped
//
// state | meaning
// IDLE  | waiting for trig
// DELAY | counting down the start delay before the first rcv sample
// HUNT  | counting rcv highs, timeout running
// CHECK | occurrence count reached; cmpl is sampled on the next edge
module goto_rep_ch
  import goto_rep_pkg::*;
#(
  parameter int START_DLY = DEF_START_DLY,
  parameter int REP_CNT   = DEF_REP_CNT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  input  logic rcv,
  input  logic cmpl,
  output logic pass,
  output logic fail,
  output logic busy,
  output logic overlap
);

  localparam int OCC_W = $clog2(REP_CNT + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  // DELAY is entered on the trig edge and left START_DLY-1 edges later, so
  // the down-counter starts at START_DLY-2 and exits on zero.
  localparam logic [3:0]       DLY_LOAD = (START_DLY > 1) ? 4'(START_DLY - 2) : 4'd0;
  localparam logic [3:0]       DLY_ONE  = 4'd1;
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_LAST = OCC_W'(REP_CNT - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  goto_state_e      r_state, w_state_nxt;
  logic [3:0]       r_dly_cnt, w_dly_nxt;
  logic [OCC_W-1:0] r_occ_cnt, w_occ_nxt;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_fail, w_fail_nxt;
  logic             r_overlap, w_overlap_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_dly_cnt <= '0;
      r_occ_cnt <= '0;
      r_tmo_cnt <= '0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_overlap <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dly_cnt <= w_dly_nxt;
      r_occ_cnt <= w_occ_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      r_pass    <= w_pass_nxt;
      r_fail    <= w_fail_nxt;
      r_overlap <= w_overlap_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dly_nxt     = r_dly_cnt;
    w_occ_nxt     = r_occ_cnt;
    w_tmo_nxt     = r_tmo_cnt;
    w_pass_nxt    = 1'b0;
    w_fail_nxt    = 1'b0;
    // Any trig outside IDLE is dropped, including on the resolving edge.
    w_overlap_nxt = trig && (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (trig) begin
          w_dly_nxt   = DLY_LOAD;
          w_occ_nxt   = '0;
          w_tmo_nxt   = TMO_LOAD;
          w_state_nxt = (START_DLY > 1) ? DELAY : HUNT;
        end
      end
      DELAY: begin
        if (r_dly_cnt == 4'd0) begin
          w_state_nxt = HUNT;
        end else begin
          w_dly_nxt = r_dly_cnt - DLY_ONE;
        end
      end
      HUNT: begin
        // Reaching the count wins over a timeout on the same edge.
        if (rcv && (r_occ_cnt == OCC_LAST)) begin
          w_occ_nxt   = r_occ_cnt + OCC_ONE;
          w_state_nxt = CHECK;
        end else begin
          if (rcv) begin
            w_occ_nxt = r_occ_cnt + OCC_ONE;
          end
          if (r_tmo_cnt == TMO_ONE) begin
            w_fail_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_tmo_nxt = r_tmo_cnt - TMO_ONE;
          end
        end
      end
      CHECK: begin
        w_pass_nxt  = cmpl;
        w_fail_nxt  = !cmpl;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign pass    = r_pass;
  assign fail    = r_fail;
  assign busy    = (r_state != IDLE);
  assign overlap = r_overlap;

endmodule

// File: rtl/goto_rep_checker.sv
// goto_rep_checker
// NUM_CH independent goto-repetition checker channels (goto_rep_ch), plus
// optional pass/fail statistics enabled by defining GOTO_REP_STATS_EN.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   trig[NUM_CH]            per-channel antecedent
//   rcv[NUM_CH]             per-channel repeated event
//   cmpl[NUM_CH]            per-channel completion event
//   pass/fail[NUM_CH]       one-cycle result pulses
//   busy[NUM_CH]            channel not IDLE
//   overlap[NUM_CH]         one-cycle pulse: trig dropped while busy
//   pass_cnt, fail_cnt      (GOTO_REP_STATS_EN only) saturating totals of
//                           pass/fail pulses over all channels
module goto_rep_checker
  import goto_rep_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int START_DLY = DEF_START_DLY,
  parameter int REP_CNT   = DEF_REP_CNT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] rcv,
  input  logic [NUM_CH-1:0] cmpl,
  output logic [NUM_CH-1:0] pass,
  output logic [NUM_CH-1:0] fail,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] overlap
`ifdef GOTO_REP_STATS_EN
  ,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       fail_cnt
`endif
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    goto_rep_ch #(
      .START_DLY(START_DLY),
      .REP_CNT  (REP_CNT),
      .TIMEOUT  (TIMEOUT)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .trig   (trig[g]),
      .rcv    (rcv[g]),
      .cmpl   (cmpl[g]),
      .pass   (pass[g]),
      .fail   (fail[g]),
      .busy   (busy[g]),
      .overlap(overlap[g])
    );
  end

`ifdef GOTO_REP_STATS_EN
  logic [STAT_W-1:0] r_pass_cnt, r_fail_cnt;
  logic [STAT_W:0]   w_pass_sum, w_fail_sum;

  // One extra bit catches the carry out; any carry means saturate.
  always_comb begin
    w_pass_sum = {1'b0, r_pass_cnt};
    w_fail_sum = {1'b0, r_fail_cnt};
    for (int i = 0; i < NUM_CH; i++) begin
      w_pass_sum = w_pass_sum + (STAT_W + 1)'(pass[i]);
      w_fail_sum = w_fail_sum + (STAT_W + 1)'(fail[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_pass_cnt <= w_pass_sum[STAT_W] ? '1 : w_pass_sum[STAT_W-1:0];
      r_fail_cnt <= w_fail_sum[STAT_W] ? '1 : w_fail_sum[STAT_W-1:0];
    end
  end

  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;
`endif

endmodule

// File: tb/tb_goto_rep_checker.sv
module tb_goto_rep_checker;

  localparam int NCH = 4;
  localparam int NE  = 24;
  localparam int NV  = 9;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] trig = '0;
  logic [NCH-1:0] rcv = '0;
  logic [NCH-1:0] cmpl = '0;
  logic [NCH-1:0] pass, fail, busy, overlap;
`ifdef GOTO_REP_STATS_EN
  logic [15:0]    pass_cnt, fail_cnt;
`endif

  goto_rep_checker #(
    .NUM_CH(NCH), .START_DLY(2), .REP_CNT(2), .TIMEOUT(16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .trig   (trig),
    .rcv    (rcv),
    .cmpl   (cmpl),
    .pass   (pass),
    .fail   (fail),
    .busy   (busy),
    .overlap(overlap)
`ifdef GOTO_REP_STATS_EN
    ,
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bit e of every mask refers to edge e of the scenario (inputs sampled at
  // edge e, outputs observed in the cycle after edge e).
  typedef struct {
    string       name;
    logic [31:0] trig, rcv, cmpl;
    logic [31:0] e_pass, e_fail, e_ovl, e_busy;
  } vec_t;

  typedef struct {
    logic [NCH-1:0] pass, fail, ovl, busy;
  } exp_t;

  vec_t vt[NV];
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] b(input int e);
    logic [31:0] m;
    m = '0;
    m[e] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_multi(input string lbl, input int vsel[NCH]);
    exp_t x, y;
    for (int e = 1; e <= NE; e++) begin
      @(negedge clk);
      x.pass = '0; x.fail = '0; x.ovl = '0; x.busy = '0;
      for (int c = 0; c < NCH; c++) begin
        if (vsel[c] >= 0) begin
          trig[c]   = vt[vsel[c]].trig[e];
          rcv[c]    = vt[vsel[c]].rcv[e];
          cmpl[c]   = vt[vsel[c]].cmpl[e];
          x.pass[c] = vt[vsel[c]].e_pass[e];
          x.fail[c] = vt[vsel[c]].e_fail[e];
          x.ovl[c]  = vt[vsel[c]].e_ovl[e];
          x.busy[c] = vt[vsel[c]].e_busy[e];
        end else begin
          trig[c] = 1'b0; rcv[c] = 1'b0; cmpl[c] = 1'b0;
        end
      end
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk($sformatf("%s scoreboard empty e%0d", lbl, e), 32'd0, 32'd1);
      end else begin
        y = sb.pop_front();
        chk($sformatf("%s pass e%0d", lbl, e), 32'(pass), 32'(y.pass));
        chk($sformatf("%s fail e%0d", lbl, e), 32'(fail), 32'(y.fail));
        chk($sformatf("%s overlap e%0d", lbl, e), 32'(overlap), 32'(y.ovl));
        chk($sformatf("%s busy e%0d", lbl, e), 32'(busy), 32'(y.busy));
      end
    end
    @(negedge clk);
    trig = '0; rcv = '0; cmpl = '0;
  endtask

  initial begin
    int sel[NCH];
    vt[0] = '{name:"single", trig:b(1), rcv:b(3)|b(5), cmpl:b(6),
              e_pass:b(6), e_fail:'0, e_ovl:'0, e_busy:rng(1,5)};
    vt[1] = '{name:"b2b_pass", trig:b(1), rcv:b(3)|b(4), cmpl:b(5),
              e_pass:b(5), e_fail:'0, e_ovl:'0, e_busy:rng(1,4)};
    vt[2] = '{name:"b2b_fail", trig:b(1), rcv:b(3)|b(4), cmpl:'0,
              e_pass:'0, e_fail:b(5), e_ovl:'0, e_busy:rng(1,4)};
    vt[3] = '{name:"early_rcv", trig:b(1), rcv:b(2), cmpl:'0,
              e_pass:'0, e_fail:b(18), e_ovl:'0, e_busy:rng(1,17)};
    vt[4] = '{name:"trig_held", trig:rng(1,4), rcv:'0, cmpl:'0,
              e_pass:'0, e_fail:b(18), e_ovl:rng(2,4), e_busy:rng(1,17)};
    vt[5] = '{name:"trig_on_check", trig:b(1)|b(5)|b(6), rcv:b(3)|b(4)|b(8)|b(9),
              cmpl:b(5)|b(10), e_pass:b(5)|b(10), e_fail:'0, e_ovl:b(5),
              e_busy:rng(1,4)|rng(6,9)};
    vt[6] = '{name:"trig_on_timeout", trig:b(1)|b(18), rcv:'0, cmpl:'0,
              e_pass:'0, e_fail:b(18), e_ovl:b(18), e_busy:rng(1,17)};
    vt[7] = '{name:"last_edge_hit", trig:b(1), rcv:b(3)|b(18), cmpl:b(19),
              e_pass:b(19), e_fail:'0, e_ovl:'0, e_busy:rng(1,18)};
    vt[8] = '{name:"one_rcv_timeout", trig:b(1), rcv:b(10), cmpl:b(12),
              e_pass:'0, e_fail:b(18), e_ovl:'0, e_busy:rng(1,17)};

    // Reset state
    #12;
    chk("reset pass", 32'(pass), 32'd0);
    chk("reset fail", 32'(fail), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset overlap", 32'(overlap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, rotated over the channels
    for (int i = 0; i < NV; i++) begin
      for (int c = 0; c < NCH; c++) sel[c] = -1;
      sel[i % NCH] = i;
      run_multi(vt[i].name, sel);
    end

    // Independent channels running different scenarios together
    sel = '{0, 1, 2, 4};
    run_multi("mixed", sel);

    // All channels passing on the same edge
`ifdef GOTO_REP_STATS_EN
    begin
      logic [15:0] p0;
      logic [15:0] f0;
      p0 = pass_cnt;
      f0 = fail_cnt;
      sel = '{1, 1, 1, 1};
      run_multi("all_pass", sel);
      chk("stats pass +4", 32'(pass_cnt), 32'(p0 + 16'd4));
      chk("stats fail unchanged", 32'(fail_cnt), 32'(f0));
      @(negedge clk);
      force dut.r_pass_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.r_pass_cnt;
      run_multi("all_pass_sat", sel);
      chk("stats pass saturate", 32'(pass_cnt), 32'h0000FFFF);
      run_multi("all_pass_sat2", sel);
      chk("stats pass hold", 32'(pass_cnt), 32'h0000FFFF);
    end
`else
    sel = '{1, 1, 1, 1};
    run_multi("all_pass", sel);
`endif

    // Reset mid-attempt: trig@1, rcv@3, reset at edge 4, new trig@8
    @(negedge clk); trig[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst seq busy after trig", 32'(busy), 32'd1);
    @(negedge clk); trig[0] = 1'b0;
    @(posedge clk);
    @(negedge clk); rcv[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst seq busy in hunt", 32'(busy), 32'd1);
    @(negedge clk); rcv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst seq busy drops", 32'(busy), 32'd0);
    for (int e = 5; e <= 7; e++) begin
      if (e == 7) begin
        @(negedge clk); rst_n = 1'b1;
      end
      @(posedge clk); #1;
      chk($sformatf("rst seq pass e%0d", e), 32'(pass), 32'd0);
      chk($sformatf("rst seq fail e%0d", e), 32'(fail), 32'd0);
      chk($sformatf("rst seq busy e%0d", e), 32'(busy), 32'd0);
    end
    @(negedge clk); trig[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst seq trig accepted", 32'(busy), 32'd1);
    for (int e = 9; e <= 13; e++) begin
      @(negedge clk);
      trig[0] = 1'b0;
      rcv[0]  = (e == 10) || (e == 11);
      cmpl[0] = (e == 12);
      @(posedge clk); #1;
      chk($sformatf("rst seq pass e%0d", e), 32'(pass), (e == 12) ? 32'd1 : 32'd0);
      chk($sformatf("rst seq fail e%0d", e), 32'(fail), 32'd0);
    end
    @(negedge clk);
    trig = '0; rcv = '0; cmpl = '0;

    if (sb.size() != 0) chk("scoreboard leftover", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
